// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: register scoreboard interlock plus a branch-hold FSM.
// Optional FWD_EN: EX/MEM forwarding exists, so only loads are tracked in the scoreboard.
module id_issue_ctrl #(
    parameter int INST_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [INST_W-1:0]     id_inst,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic                  id_ready,
    output logic                  stall,
    output logic                  flush,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  br_resolve,
    input  logic                  br_taken,
    output logic [NUM_REGS-1:0]   sb_busy,
    output logic [1:0]            dbg_state
);

    // Handshake: an instruction moves IF/ID -> ID/EX in a cycle where
    // ex_valid and id_ready are both high; they are always equal and both
    // mean "issued this cycle". stall marks a valid instruction that was held.

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_BR_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [NUM_REGS-1:0]   sb_q, sb_d;

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic                  use_rs1, use_rs2, use_rd, is_load, is_ctrl;
    logic                  track_rd, hazard, issue;
    logic                  unused_inst_bits;

    assign opcode = id_inst[6:0];
    assign rd     = id_inst[11:7];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];
    assign unused_inst_bits = ^{id_inst[INST_W-1:25], id_inst[14:12]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        is_load = 1'b0;
        is_ctrl = 1'b0;
        case (opcode)
            OP_R:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
            OP_IMM:  begin use_rs1 = 1'b1; use_rd = 1'b1; end
            OP_LOAD: begin use_rs1 = 1'b1; use_rd = 1'b1; is_load = 1'b1; end
            OP_S:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_B:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_ctrl = 1'b1; end
            OP_J:    begin use_rd = 1'b1; is_ctrl = 1'b1; end
            default: ;
        endcase
    end

    // With forwarding only loads leave a result the next instruction cannot see.
    assign track_rd = use_rd && (is_load || !FWD) && (rd != '0);

    // Hazards read only the registered scoreboard; a same-cycle writeback does not bypass.
    assign hazard = (use_rs1 && (rs1 != '0) && sb_q[rs1])
                 || (use_rs2 && (rs2 != '0) && sb_q[rs2])
                 || (use_rd  && (rd  != '0) && sb_q[rd]);

    assign issue    = !rst && if_valid && ex_ready && (state_q == S_RUN) && !hazard;
    assign ex_valid = issue;
    assign id_ready = issue;
    assign stall    = !rst && if_valid && !issue;
    assign flush    = (state_q == S_FLUSH);
    assign sb_busy  = sb_q;
    assign dbg_state = state_q;

    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        sb_d = sb_q;
        if (wb_valid) begin
            sb_d[wb_rd] = 1'b0;
        end
        if (issue && track_rd) begin
            sb_d[rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (issue && is_ctrl) begin
                    state_d = S_BR_WAIT;
                end
            end
            S_BR_WAIT: begin
                if (br_resolve) begin
                    state_d = br_taken ? S_FLUSH : S_RUN;
                end
            end
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            sb_q    <= sb_d;
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: directed cycle table, reset-in-branch sequence, and
// randomized traffic checked against an instruction-level scoreboard model.
module tb_id_issue_ctrl;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [31:0] LW5    = 32'h0000A283;
    localparam logic [31:0] LW6    = 32'h0000A303;
    localparam logic [31:0] ADD6   = 32'h00528333;
    localparam logic [31:0] ADDI7  = 32'h00100393;
    localparam logic [31:0] ADD8_7 = 32'h00738433;
    localparam logic [31:0] BEQ    = 32'h00000463;
    localparam logic [31:0] ADDI0  = 32'h00108013;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, ex_ready, wb_valid, br_resolve, br_taken;
    logic [31:0] id_inst;
    logic [4:0]  wb_rd;
    logic        ex_valid, id_ready, stall, flush;
    logic [31:0] sb_busy;
    logic [1:0]  dbg_state;

    id_issue_ctrl dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .id_inst(id_inst),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .id_ready(id_ready),
        .stall(stall), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .br_resolve(br_resolve), .br_taken(br_taken), .sb_busy(sb_busy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [35:0] exp_q[$];

    typedef struct {
        logic ifv; logic [31:0] inst; logic exr; logic wbv; logic [4:0] wbrd;
        logic brr; logic brt; logic ev; logic st; logic fl; logic [31:0] busy;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [35:0] outs();
        return {ex_valid, id_ready, stall, flush, sb_busy};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got={ev,rdy,st,fl,busy}=%h want=%h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic ifv, input logic [31:0] inst, input logic exr,
                         input logic wbv, input logic [4:0] wbrd, input logic brr, input logic brt);
        @(posedge clk);
        #1;
        if_valid = ifv; id_inst = inst; ex_ready = exr;
        wb_valid = wbv; wb_rd = wbrd; br_resolve = brr; br_taken = brt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        if_valid = 1'b1; id_inst = ADDI7; ex_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = 5'd0; br_resolve = 1'b0; br_taken = 1'b0;
        @(negedge clk);
        check("reset_outputs", outs(), 36'h0);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        rst = 1'b0;
    endtask

    function automatic void add(input logic ifv, input logic [31:0] inst, input logic exr,
                                input logic wbv, input logic [4:0] wbrd, input logic brr,
                                input logic brt, input logic ev, input logic st, input logic fl,
                                input logic [31:0] busy);
        vec_t v;
        v.ifv = ifv; v.inst = inst; v.exr = exr; v.wbv = wbv; v.wbrd = wbrd;
        v.brr = brr; v.brt = brt; v.ev = ev; v.st = st; v.fl = fl; v.busy = busy;
        tbl.push_back(v);
    endfunction

    // Reference model: pending-register set and a branch-hold mode, updated per instruction.
    bit pend[32];
    int mode;   // 0 = issuing, 1 = waiting for branch outcome, 2 = flushing

    task automatic gen_inst(output logic [31:0] inst, output int s1, output int s2,
                            output int dst, output bit ld, output bit ctl);
        logic [4:0]  a, b, d;
        logic [19:0] junk;
        int kind;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        junk = 20'($urandom);
        kind = $urandom_range(0, 6);
        s1 = -1; s2 = -1; dst = -1; ld = 0; ctl = 0;
        case (kind)
            0: begin inst = {7'd0, b, a, 3'd0, d, 7'h33}; s1 = a; s2 = b; dst = d; end
            1: begin inst = {junk[11:0], a, 3'd0, d, 7'h13}; s1 = a; dst = d; end
            2: begin inst = {junk[11:0], a, 3'd2, d, 7'h03}; s1 = a; dst = d; ld = 1; end
            3: begin inst = {7'd0, b, a, 3'd2, d, 7'h23}; s1 = a; s2 = b; end
            4: begin inst = {7'd0, b, a, 3'd0, 5'd0, 7'h63}; s1 = a; s2 = b; ctl = 1; end
            5: begin inst = {junk, d, 7'h6f}; dst = d; ctl = 1; end
            default: begin inst = {junk, d, 7'h37}; end
        endcase
    endtask

    initial begin
        logic [31:0] inst, busy;
        int s1, s2, dst;
        bit ld, ctl, haz, iss, ifv, exr, wbv, brr, brt;
        logic [4:0] wbrd;
        logic [35:0] exp;

        rst = 1'b1;
        if_valid = 1'b0; id_inst = 32'h0; ex_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; br_resolve = 1'b0; br_taken = 1'b0;
        #12;
        check("reset_idle", outs(), 36'h0);
        do_reset();

        // Directed cycle table starting from a clean scoreboard.
        add(1, LW5,    1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        add(1, ADD6,   1, 0, 0, 0, 0, 0, 1, 0, 32'h20);
        add(1, ADD6,   1, 1, 5, 0, 0, 0, 1, 0, 32'h20);
        add(1, ADD6,   1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        add(0, 32'h0,  1, 0, 0, 0, 0, 0, 0, 0, FWD ? 32'h0 : 32'h40);
        add(0, 32'h0,  1, 1, 6, 0, 0, 0, 0, 0, FWD ? 32'h0 : 32'h40);
        add(1, ADDI7,  1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        add(1, ADD8_7, 1, 0, 0, 0, 0, FWD, !FWD, 0, FWD ? 32'h0 : 32'h80);
        add(1, ADD8_7, 1, 1, 7, 0, 0, FWD, !FWD, 0, FWD ? 32'h0 : 32'h80);
        add(1, ADD8_7, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        add(0, 32'h0,  1, 1, 8, 0, 0, 0, 0, 0, FWD ? 32'h0 : 32'h100);
        add(1, BEQ,    1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        add(1, ADDI7,  1, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        add(1, ADDI7,  1, 0, 0, 1, 1, 0, 1, 0, 32'h0);
        add(1, ADDI7,  1, 0, 0, 0, 0, 0, 1, 1, 32'h0);
        add(1, ADDI7,  1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        add(1, BEQ,    1, 1, 7, 0, 0, 1, 0, 0, FWD ? 32'h0 : 32'h80);
        add(1, ADD8_7, 1, 0, 0, 1, 0, 0, 1, 0, 32'h0);
        add(1, ADD8_7, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        add(0, 32'h0,  1, 1, 8, 0, 0, 0, 0, 0, FWD ? 32'h0 : 32'h100);
        add(1, ADDI7,  1, 1, 7, 0, 0, 1, 0, 0, 32'h0);
        add(0, 32'h0,  1, 0, 0, 0, 0, 0, 0, 0, FWD ? 32'h0 : 32'h80);
        add(1, ADDI0,  1, 1, 7, 0, 0, 1, 0, 0, FWD ? 32'h0 : 32'h80);
        add(0, 32'h0,  1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        add(1, ADDI7,  0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        add(0, 32'h0,  1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        add(1, BEQ,    1, 0, 0, 1, 1, 1, 0, 0, 32'h0);
        add(0, 32'h0,  1, 0, 0, 1, 0, 0, 0, 0, 32'h0);
        add(1, ADDI7,  1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ifv, tbl[i].inst, tbl[i].exr, tbl[i].wbv, tbl[i].wbrd,
                  tbl[i].brr, tbl[i].brt);
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].ev, tbl[i].ev, tbl[i].st, tbl[i].fl, tbl[i].busy});
        end

        // Reset while a branch is outstanding and two loads are pending.
        do_reset();
        drive(1, LW5, 1, 0, 0, 0, 0);
        check("rst_seq_lw5", outs(), {4'b1100, 32'h0});
        drive(1, LW6, 1, 0, 0, 0, 0);
        check("rst_seq_lw6", outs(), {4'b1100, 32'h20});
        drive(1, BEQ, 1, 0, 0, 0, 0);
        check("rst_seq_beq", outs(), {4'b1100, 32'h60});
        drive(1, ADDI7, 1, 0, 0, 0, 0);
        check("rst_seq_wait", outs(), {4'b0010, 32'h60});
        rst = 1'b1;
        #1;
        check("rst_seq_async", outs(), 36'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_seq_resume", outs(), {4'b1100, 32'h0});

        // Randomized traffic against the reference model.
        do_reset();
        for (int r = 0; r < 32; r++) pend[r] = 0;
        mode = 0;
        for (int n = 0; n < 1500; n++) begin
            gen_inst(inst, s1, s2, dst, ld, ctl);
            ifv  = ($urandom_range(0, 9) < 8);
            exr  = ($urandom_range(0, 9) < 8);
            wbv  = ($urandom_range(0, 9) < 4);
            wbrd = 5'($urandom_range(0, 7));
            brr  = ($urandom_range(0, 9) < 3);
            brt  = $urandom_range(0, 1);
            haz = 0;
            if (s1 > 0 && pend[s1]) haz = 1;
            if (s2 > 0 && pend[s2]) haz = 1;
            if (dst > 0 && pend[dst]) haz = 1;
            iss = ifv && exr && (mode == 0) && !haz;
            for (int r = 0; r < 32; r++) busy[r] = pend[r];
            exp_q.push_back({iss, iss, ifv && !iss, mode == 2, busy});
            drive(ifv, inst, exr, wbv, wbrd, brr, brt);
            exp = exp_q.pop_front();
            check($sformatf("rand%0d inst=%h", n, inst), outs(), exp);
            if (wbv) pend[wbrd] = 0;
            if (iss && dst > 0 && (ld || !FWD)) pend[dst] = 1;
            if (mode == 0) mode = (iss && ctl) ? 1 : 0;
            else if (mode == 1) begin
                if (brr) mode = brt ? 2 : 0;
            end else mode = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
